// File: rtl/agu_pkg.sv
// Default geometry and base addresses for the data-memory AGU, plus the derived row stride.
package agu_pkg;
    localparam int IMG_W      = 128;
    localparam int IMG_H      = 128;
    localparam int COL_STEP   = 2;
    localparam int ROW_STEP   = 2;
    localparam int SRC_BASE   = 0;
    localparam int DST_BASE   = 16384;
    localparam int ROW_STRIDE = IMG_W * ROW_STEP;

    // Elaboration-time only; lets overridden instances derive their own stride.
    function automatic int row_stride(input int img_w, input int row_step);
        return img_w * row_step;
    endfunction
endpackage

// File: rtl/step_wrap_counter.sv
// Counter advancing by STEP per inc, wrapping to 0 when the next value would reach LIMIT.
// clr beats inc; wrap is a same-cycle pulse meaning "this edge wraps".
module step_wrap_counter #(
    parameter int W     = 16,
    parameter int STEP  = 1,
    parameter int LIMIT = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    logic [W:0] sum;

    // One extra bit so the limit compare cannot be fooled by overflow.
    assign sum  = {1'b0, cnt} + (W+1)'(STEP);
    assign wrap = enable && !clr && inc && (sum >= (W+1)'(LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (enable) begin
            if (clr)
                cnt <= '0;
            else if (inc)
                cnt <= wrap ? '0 : sum[W-1:0];
        end
    end
endmodule

// File: rtl/dmem_agu.sv
// Data-memory AGU: strided image reads, linear MAR writes; address/enables registered, 1-cycle latency.
// No backpressure: a strobe is accepted every enabled cycle; enable low holds state and drops enables.
module dmem_agu
    import agu_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int IMG_W    = agu_pkg::IMG_W,
    parameter int IMG_H    = agu_pkg::IMG_H,
    parameter int COL_STEP = agu_pkg::COL_STEP,
    parameter int ROW_STEP = agu_pkg::ROW_STEP,
    parameter int SRC_BASE = agu_pkg::SRC_BASE,
    parameter int DST_BASE = agu_pkg::DST_BASE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mar_inc,
    input  logic              col_inc,
    input  logic              row_inc,
    input  logic              col_zero,
    input  logic              dmem_read,
    input  logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_re,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mar,
    output logic [ADDR_W-1:0] col,
    output logic [ADDR_W-1:0] row,
    output logic              frame_done,
    output logic              req_conflict
);
    localparam int STRIDE = row_stride(IMG_W, ROW_STEP);

    logic [ADDR_W-1:0] row_base;
    logic              row_wrap;
    logic              col_wrap;

    step_wrap_counter #(.W(ADDR_W), .STEP(COL_STEP), .LIMIT(IMG_W)) u_col (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clr    (col_zero),
        .inc    (col_inc),
        .cnt    (col),
        .wrap   (col_wrap)
    );

    step_wrap_counter #(.W(ADDR_W), .STEP(ROW_STEP), .LIMIT(IMG_H)) u_row (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clr    (1'b0),
        .inc    (row_inc),
        .cnt    (row),
        .wrap   (row_wrap)
    );

    // row_base tracks row*IMG_W by accumulation so no multiplier is built.
    always_ff @(posedge clk) begin
        if (reset) begin
            mar        <= '0;
            row_base   <= '0;
            frame_done <= 1'b0;
        end else if (enable) begin
            if (mar_inc)
                mar <= mar + ADDR_W'(1);
            if (row_inc)
                row_base <= row_wrap ? '0 : row_base + ADDR_W'(STRIDE);
            if (row_wrap)
                frame_done <= 1'b1;
        end
    end

    // Addresses use pre-update counter values; write wins a simultaneous request.
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_addr    <= '0;
            dmem_re      <= 1'b0;
            dmem_we      <= 1'b0;
            req_conflict <= 1'b0;
        end else if (!enable) begin
            dmem_re <= 1'b0;
            dmem_we <= 1'b0;
        end else begin
            dmem_re <= dmem_read && !dmem_write;
            dmem_we <= dmem_write;
            if (dmem_write)
                dmem_addr <= ADDR_W'(DST_BASE) + mar;
            else if (dmem_read)
                dmem_addr <= ADDR_W'(SRC_BASE) + row_base + col;
            if (dmem_read && dmem_write)
                req_conflict <= 1'b1;
        end
    end

    logic unused_ok;
    assign unused_ok = col_wrap;
endmodule

// File: tb/tb_dmem_agu.sv
// Directed bench for dmem_agu with hand-computed expectations.
module tb_dmem_agu;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset, enable;
    logic              mar_inc, col_inc, row_inc, col_zero, dmem_read, dmem_write;
    logic [ADDR_W-1:0] dmem_addr, mar, col, row;
    logic              dmem_re, dmem_we, frame_done, req_conflict;

    int checks = 0;
    int errors = 0;

    dmem_agu dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .mar_inc      (mar_inc),
        .col_inc      (col_inc),
        .row_inc      (row_inc),
        .col_zero     (col_zero),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_addr    (dmem_addr),
        .dmem_re      (dmem_re),
        .dmem_we      (dmem_we),
        .mar          (mar),
        .col          (col),
        .row          (row),
        .frame_done   (frame_done),
        .req_conflict (req_conflict)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mar_inc = 0; col_inc = 0; row_inc = 0; col_zero = 0;
        dmem_read = 0; dmem_write = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, 32'(dmem_addr), 0);
        chk({tag, "_re"}, 32'(dmem_re), 0);
        chk({tag, "_we"}, 32'(dmem_we), 0);
        chk({tag, "_mar"}, 32'(mar), 0);
        chk({tag, "_col"}, 32'(col), 0);
        chk({tag, "_row"}, 32'(row), 0);
        chk({tag, "_frame"}, 32'(frame_done), 0);
        chk({tag, "_conf"}, 32'(req_conflict), 0);
    endtask

    initial begin
        idle();
        enable = 1; reset = 1;
        tick();
        reset = 0;
        chk_all_zero("rst");

        // Three column steps then a read: addr = 0 + 0 + 6.
        col_inc = 1;
        repeat (3) tick();
        col_inc = 0; dmem_read = 1;
        tick();
        chk("rd1_addr", 32'(dmem_addr), 6);
        chk("rd1_re", 32'(dmem_re), 1);
        chk("rd1_we", 32'(dmem_we), 0);
        dmem_read = 0;
        tick();
        chk("rd1_re_drop", 32'(dmem_re), 0);
        chk("rd1_addr_hold", 32'(dmem_addr), 6);

        // Column to 126, then wrap at IMG_W.
        col_inc = 1;
        repeat (60) tick();
        chk("col_126", 32'(col), 126);
        tick();
        chk("col_wrap", 32'(col), 0);
        repeat (63) tick();
        chk("col_126b", 32'(col), 126);
        col_inc = 0;

        // Row increment state: row_inc + col_zero together.
        row_inc = 1; col_zero = 1;
        tick();
        row_inc = 0; col_zero = 0;
        chk("rowinc_col", 32'(col), 0);
        chk("rowinc_row", 32'(row), 2);
        dmem_read = 1;
        tick();
        dmem_read = 0;
        chk("rd2_addr", 32'(dmem_addr), 256);
        chk("rd2_re", 32'(dmem_re), 1);

        // col_zero beats col_inc.
        col_inc = 1;
        repeat (4) tick();
        chk("col_8", 32'(col), 8);
        col_zero = 1;
        tick();
        col_inc = 0; col_zero = 0;
        chk("colzero_wins", 32'(col), 0);

        // MAR walk and write address.
        mar_inc = 1;
        repeat (5) tick();
        mar_inc = 0;
        chk("mar_5", 32'(mar), 5);
        dmem_write = 1;
        tick();
        dmem_write = 0;
        chk("wr1_addr", 32'(dmem_addr), 16389);
        chk("wr1_we", 32'(dmem_we), 1);
        chk("wr1_re", 32'(dmem_re), 0);
        tick();
        chk("wr1_we_drop", 32'(dmem_we), 0);
        chk("wr1_addr_hold", 32'(dmem_addr), 16389);

        // MAR up to 65535, then write + mar_inc: old mar used, mar wraps.
        mar_inc = 1;
        repeat (65530) tick();
        chk("mar_max", 32'(mar), 65535);
        dmem_write = 1;
        tick();
        mar_inc = 0; dmem_write = 0;
        chk("mar_wrap", 32'(mar), 0);
        chk("wr2_addr", 32'(dmem_addr), 16383);
        chk("wr2_we", 32'(dmem_we), 1);

        // Row walk from 2 up to the frame wrap.
        row_inc = 1;
        repeat (62) tick();
        chk("row_126", 32'(row), 126);
        chk("frame_pre", 32'(frame_done), 0);
        tick();
        row_inc = 0;
        chk("row_wrap", 32'(row), 0);
        chk("frame_set", 32'(frame_done), 1);
        dmem_read = 1;
        tick();
        dmem_read = 0;
        chk("rd3_addr", 32'(dmem_addr), 0);
        row_inc = 1;
        tick();
        row_inc = 0;
        chk("row_2b", 32'(row), 2);
        chk("frame_sticky", 32'(frame_done), 1);

        // Simultaneous read and write at mar=3.
        mar_inc = 1;
        repeat (3) tick();
        mar_inc = 0;
        chk("conf_pre", 32'(req_conflict), 0);
        dmem_read = 1; dmem_write = 1;
        tick();
        dmem_read = 0; dmem_write = 0;
        chk("conf_we", 32'(dmem_we), 1);
        chk("conf_re", 32'(dmem_re), 0);
        chk("conf_addr", 32'(dmem_addr), 16387);
        chk("conf_flag", 32'(req_conflict), 1);
        tick();
        chk("conf_sticky", 32'(req_conflict), 1);

        // Position row=4, col=8, issue a read, then stall with every strobe high.
        row_inc = 1;
        tick();
        row_inc = 0; col_inc = 1;
        repeat (4) tick();
        col_inc = 0; dmem_read = 1;
        tick();
        chk("rd4_addr", 32'(dmem_addr), 520);
        chk("rd4_re", 32'(dmem_re), 1);
        enable = 0;
        mar_inc = 1; col_inc = 1; row_inc = 1; col_zero = 1; dmem_write = 1;
        tick();
        chk("dis_re", 32'(dmem_re), 0);
        chk("dis_we", 32'(dmem_we), 0);
        tick();
        chk("dis_col", 32'(col), 8);
        chk("dis_row", 32'(row), 4);
        chk("dis_mar", 32'(mar), 3);
        chk("dis_addr", 32'(dmem_addr), 520);
        chk("dis_re2", 32'(dmem_re), 0);

        // Reset mid-walk with strobes and enable high.
        enable = 1; reset = 1;
        tick();
        reset = 0;
        idle();
        chk_all_zero("rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
